// File: rtl/memory_stage.sv
// Memory (M) pipeline stage: issues loads and stores on the data bus,
// stalls until the bus completes, and forms the bundle for writeback.
// Non-memory instructions flow straight through combinationally.

package common_pkg;
  typedef logic [63:0] word_t;

  typedef struct packed {
    logic [31:0] instr;
    word_t       pc;
    word_t       aluout;
    word_t       writedata;
    logic [4:0]  dst;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic [1:0]  msize;
    logic        mem_unsigned;
    logic        valid;
  } execute_data_t;

  typedef struct packed {
    logic [31:0] instr;
    word_t       pc;
    word_t       aluout;
    word_t       readdata;
    logic [4:0]  dst;
    logic        regwrite;
    logic        memtoreg;
    logic        valid;
  } memory_data_t;
endpackage

module memory_stage
  import common_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  input  logic          hold,
  output logic          dreq_valid,
  output word_t         dreq_addr,
  output logic [2:0]    dreq_size,
  output logic [7:0]    dreq_strobe,
  output word_t         dreq_data,
  input  logic          dresp_data_ok,
  input  word_t         dresp_data,
  output memory_data_t  dataM,
  output logic          stallM,
  output logic          misalign
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t     state, stateNext;
  logic [2:0] offset;
  logic       memOp, misaligned;
  logic [7:0] sizeMask;

  // request registers; the bus sees only these so fields stay stable in REQ
  word_t      reqAddr, reqData;
  logic [2:0] reqSize, reqOffset;
  logic [7:0] reqStrobe;
  logic [1:0] reqMsize;
  logic       reqUnsigned, reqLoad;

  word_t      lane, loadVal, rdataQ;

  assign offset = dataE.aluout[2:0];
  assign memOp  = dataE.valid & (dataE.memread | dataE.memwrite);

  // access-size byte mask and alignment check
  always_comb begin
    sizeMask   = 8'h01;
    misaligned = 1'b0;
    case (dataE.msize)
      2'd0: begin sizeMask = 8'h01; misaligned = 1'b0;        end
      2'd1: begin sizeMask = 8'h03; misaligned = offset[0];   end
      2'd2: begin sizeMask = 8'h0F; misaligned = |offset[1:0]; end
      default: begin sizeMask = 8'hFF; misaligned = |offset;  end
    endcase
  end

  // extract the addressed lane from the raw bus word and extend it
  always_comb begin
    lane    = dresp_data >> {reqOffset, 3'b000};
    loadVal = lane;
    case (reqMsize)
      2'd0: loadVal = reqUnsigned ? {56'b0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      2'd1: loadVal = reqUnsigned ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'd2: loadVal = reqUnsigned ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: loadVal = lane;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // latch the request as the FSM leaves IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reqAddr     <= '0;
      reqData     <= '0;
      reqSize     <= '0;
      reqStrobe   <= '0;
      reqOffset   <= '0;
      reqMsize    <= '0;
      reqUnsigned <= 1'b0;
      reqLoad     <= 1'b0;
    end else if (state == IDLE && stateNext == REQ) begin
      reqAddr     <= {dataE.aluout[63:3], 3'b000};
      reqData     <= dataE.writedata << {offset, 3'b000};
      reqSize     <= {1'b0, dataE.msize};
      reqStrobe   <= dataE.memwrite ? (sizeMask << offset) : 8'h00;
      reqOffset   <= offset;
      reqMsize    <= dataE.msize;
      reqUnsigned <= dataE.mem_unsigned;
      reqLoad     <= dataE.memread & ~dataE.memwrite;
    end
  end

  // capture load result on completion; stores leave zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            rdataQ <= '0;
    else if (state == REQ && dresp_data_ok) rdataQ <= reqLoad ? loadVal : '0;
  end

  assign dreq_addr   = reqAddr;
  assign dreq_size   = reqSize;
  assign dreq_strobe = reqStrobe;
  assign dreq_data   = reqData;

  // next state, stall/misalign, and the writeback bundle
  always_comb begin
    stateNext      = state;
    stallM         = 1'b0;
    misalign       = 1'b0;
    dreq_valid     = 1'b0;
    dataM.instr    = dataE.instr;
    dataM.pc       = dataE.pc;
    dataM.aluout   = dataE.aluout;
    dataM.readdata = '0;
    dataM.dst      = dataE.dst;
    dataM.regwrite = dataE.regwrite;
    dataM.memtoreg = dataE.memtoreg;
    dataM.valid    = dataE.valid;
    case (state)
      IDLE: begin
        if (memOp && !misaligned) begin
          stallM    = 1'b1;
          stateNext = REQ;
        end else if (memOp) begin
          misalign       = 1'b1;
          dataM.regwrite = 1'b0;
        end
      end
      REQ: begin
        dreq_valid = 1'b1;
        stallM     = 1'b1;
        if (dresp_data_ok) stateNext = DONE;
      end
      DONE: begin
        dataM.readdata = rdataQ;
        if (!hold) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // a stalled bundle must never reach writeback
    if (stallM) dataM.valid = 1'b0;
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a readdata scoreboard.
module tb_memory_stage;
  import common_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          hold = 1'b0;
  logic          dresp_data_ok = 1'b0;
  word_t         dresp_data = '0;
  execute_data_t dataE = '0;
  logic          dreq_valid;
  word_t         dreq_addr;
  logic [2:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  word_t         dreq_data;
  memory_data_t  dataM;
  logic          stallM;
  logic          misalign;

  int    nVec = 0;
  int    nErr = 0;
  word_t sbq[$];

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .reset(reset), .dataE(dataE), .hold(hold),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .dataM(dataM), .stallM(stallM), .misalign(misalign)
  );

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic execute_data_t mk(input word_t addr, input logic rd, input logic wr,
                                       input logic [1:0] sz, input logic uns, input word_t wdata);
    execute_data_t d;
    d = '0;
    d.instr        = 32'h0000_0013;
    d.pc           = 64'h8000_0000;
    d.aluout       = addr;
    d.writedata    = wdata;
    d.dst          = 5'd7;
    d.regwrite     = ~wr;
    d.memread      = rd;
    d.memwrite     = wr;
    d.memtoreg     = rd;
    d.msize        = sz;
    d.mem_unsigned = uns;
    d.valid        = 1'b1;
    return d;
  endfunction

  // run one memory op: data_ok on the (n+1)-th REQ cycle, optional hold in DONE
  task automatic memOp(input execute_data_t d, input int n, input word_t resp,
                       input word_t expAddr, input logic [2:0] expSize,
                       input logic [7:0] expStrobe, input word_t expData,
                       input word_t expRead, input int holdCycles);
    int    stalls = 0;
    int    reqs = 0;
    logic  done = 1'b0;
    word_t expQ;
    @(posedge clk); #1;
    dataE = d;
    dresp_data = resp;
    sbq.push_back(expRead);
    @(negedge clk);
    if (stallM) stalls++;
    chkb("idle_no_req", dreq_valid, 1'b0);
    for (int c = 1; c <= n + 40 && !done; c++) begin
      @(posedge clk); #1;
      if (dreq_valid) begin
        chk("req_addr", dreq_addr, expAddr);
        chk("req_size", 64'(dreq_size), 64'(expSize));
        chk("req_strobe", 64'(dreq_strobe), 64'(expStrobe));
        chk("req_data", dreq_data, expData);
        chkb("req_m_valid", dataM.valid, 1'b0);
        dresp_data_ok = (reqs == n);
        reqs++;
      end else begin
        dresp_data_ok = 1'b0;
      end
      @(negedge clk);
      if (stallM) stalls++;
      else        done = 1'b1;
    end
    dresp_data_ok = 1'b0;
    chkb("done_reached", done, 1'b1);
    chk("stall_cycles", 64'(stalls), 64'(n + 2));
    chk("req_cycles", 64'(reqs), 64'(n + 1));
    expQ = sbq.pop_front();
    chk("readdata", dataM.readdata, expQ);
    chkb("done_m_valid", dataM.valid, 1'b1);
    if (holdCycles > 0) begin
      hold = 1'b1;
      for (int i = 0; i < holdCycles; i++) begin
        @(negedge clk);
        chkb("hold_no_req", dreq_valid, 1'b0);
        chkb("hold_no_stall", stallM, 1'b0);
        chk("hold_readdata", dataM.readdata, expQ);
      end
      hold = 1'b0;
    end
    @(posedge clk); #1;
    dataE = mk(64'h0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0);
    @(negedge clk);
    chkb("after_no_stall", stallM, 1'b0);
    chkb("after_no_req", dreq_valid, 1'b0);
    chk("after_readdata", dataM.readdata, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkb("rst_dreq_valid", dreq_valid, 1'b0);
    chkb("rst_stall", stallM, 1'b0);
    chk("rst_addr", dreq_addr, 64'h0);
    chk("rst_strobe", 64'(dreq_strobe), 64'h0);
    chk("rst_readdata", dataM.readdata, 64'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // ALU pass-through
    dataE = mk(64'h1234, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0);
    @(negedge clk);
    chkb("alu_stall", stallM, 1'b0);
    chk("alu_aluout", dataM.aluout, 64'h1234);
    chkb("alu_dreq", dreq_valid, 1'b0);
    chkb("alu_valid", dataM.valid, 1'b1);
    chkb("alu_regwrite", dataM.regwrite, 1'b1);
    @(negedge clk);
    chkb("alu_stall2", stallM, 1'b0);
    chkb("alu_dreq2", dreq_valid, 1'b0);

    // signed byte load, data_ok one cycle after request
    memOp(mk(64'h1003, 1'b1, 1'b0, 2'd0, 1'b0, 64'h0), 1, 64'h0000_0000_8000_0000,
          64'h1000, 3'd0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0);

    // half store with a 4-cycle response delay
    memOp(mk(64'h2006, 1'b0, 1'b1, 2'd1, 1'b0, 64'hABCD), 4, 64'hDEAD_BEEF_DEAD_BEEF,
          64'h2000, 3'd1, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0, 0);

    // unsigned word load, data_ok in first REQ cycle, hold in DONE
    memOp(mk(64'h3004, 1'b1, 1'b0, 2'd2, 1'b1, 64'h0), 0, 64'h8765_4321_0000_0000,
          64'h3000, 3'd2, 8'h00, 64'h0, 64'h0000_0000_8765_4321, 3);

    // aligned signed doubleword load
    memOp(mk(64'h5000, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0), 2, 64'h8000_0000_0000_0001,
          64'h5000, 3'd3, 8'h00, 64'h0, 64'h8000_0000_0000_0001, 0);

    // byte store in the top lane
    memOp(mk(64'h500F, 1'b0, 1'b1, 2'd0, 1'b0, 64'h1122_3344_5566_775A), 1, 64'h0,
          64'h5008, 3'd0, 8'h80, 64'h5A00_0000_0000_0000, 64'h0, 0);

    // misaligned doubleword load
    @(posedge clk); #1;
    dataE = mk(64'h4004, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0);
    dataE.regwrite = 1'b1;
    @(negedge clk);
    chkb("mis_flag", misalign, 1'b1);
    chkb("mis_dreq", dreq_valid, 1'b0);
    chkb("mis_regwrite", dataM.regwrite, 1'b0);
    chkb("mis_stall", stallM, 1'b0);
    chkb("mis_valid", dataM.valid, 1'b1);
    @(negedge clk);
    chkb("mis_dreq2", dreq_valid, 1'b0);
    chkb("mis_flag2", misalign, 1'b1);

    // reset during the second REQ cycle, then a stray data_ok
    @(posedge clk); #1;
    dataE = mk(64'h6000, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0);
    @(posedge clk); #1;
    chkb("rr_req1", dreq_valid, 1'b1);
    @(posedge clk); #1;
    chkb("rr_req2", dreq_valid, 1'b1);
    #2;
    reset = 1'b0;
    dataE = mk(64'h0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0);
    #1;
    chkb("rr_async_dreq", dreq_valid, 1'b0);
    chk("rr_addr", dreq_addr, 64'h0);
    chk("rr_size", 64'(dreq_size), 64'h0);
    chk("rr_strobe", 64'(dreq_strobe), 64'h0);
    chkb("rr_stall", stallM, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    dresp_data_ok = 1'b1;
    @(negedge clk);
    chkb("stray_dreq", dreq_valid, 1'b0);
    chkb("stray_stall", stallM, 1'b0);
    @(posedge clk); #1;
    dresp_data_ok = 1'b0;
    @(negedge clk);
    chkb("stray_dreq2", dreq_valid, 1'b0);
    chk("stray_readdata", dataM.readdata, 64'h0);

    // recovery: unsigned byte load at offset 7
    memOp(mk(64'h7007, 1'b1, 1'b0, 2'd0, 1'b1, 64'h0), 2, 64'h8000_0000_0000_0000,
          64'h7000, 3'd0, 8'h00, 64'h0, 64'h0000_0000_0000_0080, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline memory (M) stage: consumes the execute-stage result bundle, performs loads and stores over the data bus with a request/response handshake, and produces the memory-stage bundle for writeback. Non-memory instructions pass through combinationally. Memory instructions stall the pipeline until the bus completes. Sits between the execute stage and the writeback pipeline register.

## Interface
- No parameters; widths come from the common package (word_t = 64 bits).
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- dataE  in  execute_data_t  execute bundle: instr, pc, aluout (address or result), writedata, dst, regwrite, memread, memwrite, memtoreg, msize[1:0], mem_unsigned, valid
- hold  in  1  global pipeline hold from other stages; the M-stage bundle will not advance this cycle
- dreq_valid  out  1  data bus request valid
- dreq_addr  out  64  request address, {aluout[63:3], 3'b000}
- dreq_size  out  3  {1'b0, msize}
- dreq_strobe  out  8  byte write enables, 0 for loads
- dreq_data  out  64  write data, lane-aligned
- dresp_data_ok  in  1  response complete (load data valid / store committed)
- dresp_data  in  64  raw 8-byte load data
- dataM  out  memory_data_t  instr, pc, aluout, readdata[63:0], dst, regwrite, memtoreg, valid
- stallM  out  1  M stage busy; upstream must hold
- misalign  out  1  current memory op misaligned; no request is issued

## Operation
- msize encoding: 0=1B, 1=2B, 2=4B, 3=8B. Offset is aluout[2:0].
- memop = dataE.valid & (memread | memwrite). Misaligned means the offset is not a multiple of the access size.
- The request is latched into internal registers on the IDLE->REQ transition. The dreq_* outputs are driven from those registers.
- Store lanes: strobe = ((1<<bytes)-1) << offset. dreq_data = writedata << (8*offset).
- Load extract: lane = dresp_data >> (8*offset), truncated to the size. The result is zero-extended if mem_unsigned, else sign-extended. It is captured in rdata_q on data_ok.
- FSM, three states, reset to IDLE:
  - IDLE:
    - memop & !misalign: stallM=1, next REQ.
    - Otherwise pass-through: stallM=0, readdata=0.
    - misalign: misalign=1, stallM=0, dataM.valid=dataE.valid, regwrite forced 0.
  - REQ: dreq_valid=1 with all dreq_* fields stable, stallM=1.
    - data_ok=1: capture rdata_q, next DONE.
    - Otherwise stay in REQ.
  - DONE: stallM=0, dataM.readdata=rdata_q (0 for stores), dreq_valid=0.
    - hold=1: stay in DONE (no reissue).
    - Otherwise next IDLE.
- dataM fields other than readdata are always copied combinationally from dataE.
- dataM.valid is 0 whenever stallM=1, which prevents duplicate writeback.

## Timing
- Reset (asynchronous, any state, including mid-transaction):
  - State becomes IDLE and rdata_q becomes 0.
  - dreq_valid, dreq_strobe, dreq_addr, dreq_size and dreq_data become 0.
  - stallM then follows the IDLE rules.
  - Any outstanding response is ignored. data_ok is only sampled in REQ.
- Non-memory instruction: 0-cycle latency, stallM=0.
- Memory op, with data_ok N cycles after REQ entry (N≥0; data_ok in the first REQ cycle is legal):
  - cycle 0: IDLE, stall
  - cycles 1..N+1: REQ
  - cycle N+2: DONE, stallM=0
  - Total stall cycles = N+2. The minimum is 2.
- data_ok while not in REQ: ignored.
- hold=1 during IDLE or REQ: no effect on the FSM.

## Test plan
- ALU op (memread=memwrite=0, aluout=0x1234, valid=1) -> stallM=0 same cycle, dataM.aluout=0x1234, dreq_valid=0, no state change.
- Signed byte load at aluout=0x1003, dresp_data=0x00000000_80000000, data_ok one cycle after request -> dreq_addr=0x1000, size=0, strobe=0x00; readdata=0xFFFF_FFFF_FFFF_FF80; stallM high exactly 3 cycles.
- Half store at aluout=0x2006, writedata=0xABCD -> strobe=0xC0, dreq_data=0xABCD_0000_0000_0000; fields stable across a 4-cycle data_ok delay; readdata=0.
- Unsigned word load at 0x3004, dresp_data=0x8765_4321_0000_0000, data_ok in the first REQ cycle -> readdata=0x0000_0000_8765_4321; DONE held while hold=1 for 3 cycles with no second request.
- Doubleword load at 0x4004 -> misalign=1, dreq_valid never asserted, regwrite=0, stallM=0.
- reset=0 in the second REQ cycle, then data_ok pulsed after release -> dreq_valid drops asynchronously; FSM in IDLE; stray data_ok ignored; rdata_q=0.
